// File: rtl/equal_pkg.sv
// Shared defaults, counter type and decision states for the equal block.
// Optional arrival-tolerance feature is enabled by defining EQUAL_TOL_EN.
package equal_pkg;

  localparam int TOL_DEFAULT     = 1;
  localparam int PULSE_W_DEFAULT = 1;

  typedef logic [3:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_DONE
  } state_t;

endpackage

// File: rtl/equal_arrival.sv
// Per-input rising-edge detector that reports only the first event of a wave.
// Works the same whether or not EQUAL_TOL_EN is defined.
module equal_arrival
  import equal_pkg::*;
(
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic din,
  output logic first
);

  logic prev;
  logic flag;

  // prev comes out of global reset high so a level that is already high is never an event
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      prev <= 1'b1;
      flag <= 1'b0;
    end else if (rst) begin
      prev <= din;
      flag <= 1'b0;
    end else begin
      prev <= din;
      if (first) begin
        flag <= 1'b1;
      end
    end
  end

  assign first = din & ~prev & ~flag & ~rst;

endmodule

// File: rtl/equal.sv
// Temporal equality: pulses y when a and b rise together (or within TOL cycles
// when EQUAL_TOL_EN is defined). One decision per wave; rst starts a new wave.
module equal
  import equal_pkg::*;
#(
  parameter int TOL     = TOL_DEFAULT,
  parameter int PULSE_W = PULSE_W_DEFAULT
) (
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y
);

  localparam cnt_t PW_C = cnt_t'(PULSE_W);

  if (PULSE_W < 1 || PULSE_W > 15 || TOL < 0 || TOL > 15) begin : g_param_check
    $error("equal: TOL or PULSE_W out of range");
  end

  logic   first_a;
  logic   first_b;
  state_t state;
  state_t state_n;
  cnt_t   pcnt;
  cnt_t   pcnt_n;
  logic   y_n;

  equal_arrival u_arr_a (
    .aclk  (aclk),
    .grst  (grst),
    .rst   (rst),
    .din   (a),
    .first (first_a)
  );

  equal_arrival u_arr_b (
    .aclk  (aclk),
    .grst  (grst),
    .rst   (rst),
    .din   (b),
    .first (first_b)
  );

`ifdef EQUAL_TOL_EN
  localparam cnt_t TOL_C = cnt_t'(TOL);
  cnt_t sep;
  cnt_t sep_n;

  // sep holds the separation the next edge would have from the first arrival
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      sep <= '0;
    end else begin
      sep <= sep_n;
    end
  end
`endif

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state <= S_IDLE;
      pcnt  <= '0;
      y     <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      y     <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    y_n     = 1'b0;
`ifdef EQUAL_TOL_EN
    sep_n   = sep;
`endif
    if (rst) begin
      state_n = S_IDLE;
      pcnt_n  = '0;
`ifdef EQUAL_TOL_EN
      sep_n   = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (first_a && first_b) begin
            state_n = S_PULSE;
            pcnt_n  = cnt_t'(1);
            y_n     = 1'b1;
          end else if (first_a || first_b) begin
`ifdef EQUAL_TOL_EN
            if (TOL_C == '0) begin
              state_n = S_DONE;
            end else begin
              state_n = S_WAIT;
              sep_n   = cnt_t'(1);
            end
`else
            state_n = S_DONE;
`endif
          end
        end
        S_WAIT: begin
`ifdef EQUAL_TOL_EN
          // only the input that has not yet arrived can report a first event here
          if (first_a || first_b) begin
            state_n = S_PULSE;
            pcnt_n  = cnt_t'(1);
            y_n     = 1'b1;
          end else if (sep >= TOL_C) begin
            state_n = S_DONE;
          end else begin
            sep_n = sep + cnt_t'(1);
          end
`else
          state_n = S_DONE;
`endif
        end
        S_PULSE: begin
          if (pcnt >= PW_C) begin
            state_n = S_DONE;
          end else begin
            pcnt_n = pcnt + cnt_t'(1);
            y_n    = 1'b1;
          end
        end
        default: begin
          state_n = S_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equal.sv
// Self-checking bench for equal: two instances (PULSE_W=1/TOL=1 and PULSE_W=4/TOL=2)
// compared against an arrival-time reference model; honours EQUAL_TOL_EN.
module tb_equal;

  logic aclk;
  logic grst;
  logic rst;
  logic a;
  logic b;
  logic y1;
  logic y4;

  int checks;
  int failures;

  // reference model: wave-relative arrival edge numbers, -1 when not yet arrived
  int   t;
  int   ta;
  int   tb;
  logic last_a;
  logic last_b;

  equal #(.TOL(1), .PULSE_W(1)) dut1 (
    .aclk (aclk),
    .grst (grst),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .y    (y1)
  );

  equal #(.TOL(2), .PULSE_W(4)) dut4 (
    .aclk (aclk),
    .grst (grst),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .y    (y4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic expY(int pw, int tol);
    int eff_tol;
    int sep;
    int tf;
`ifdef EQUAL_TOL_EN
    eff_tol = tol;
`else
    eff_tol = 0;
`endif
    if (ta < 0 || tb < 0) return 1'b0;
    sep = (ta > tb) ? ta - tb : tb - ta;
    tf  = (ta > tb) ? ta : tb;
    return (sep <= eff_tol) && (t >= tf) && (t < tf + pw);
  endfunction

  task automatic modelGlobalReset();
    last_a = 1'b1;
    last_b = 1'b1;
    ta = -1;
    tb = -1;
  endtask

  task automatic modelEdge(logic sa, logic sb, logic sr);
    t++;
    if (sr) begin
      ta = -1;
      tb = -1;
    end else begin
      if (sa && !last_a && ta < 0) ta = t;
      if (sb && !last_b && tb < 0) tb = t;
    end
    last_a = sa;
    last_b = sb;
  endtask

  task automatic checkOutput(string tag, logic e1, logic e4);
    checks++;
    assert (y1 === e1) else begin
      failures++;
      $error("[TB] FAIL %s y(PW1) observed=%b expected=%b t=%0d", tag, y1, e1, t);
    end
    checks++;
    assert (y4 === e4) else begin
      failures++;
      $error("[TB] FAIL %s y(PW4) observed=%b expected=%b t=%0d", tag, y4, e4, t);
    end
  endtask

  task automatic applyStimulus(logic na, logic nb, logic nr, string tag);
    @(negedge aclk);
    a   = na;
    b   = nb;
    rst = nr;
    @(posedge aclk);
    modelEdge(na, nb, nr);
    #1;
    checkOutput(tag, expY(1, 1), expY(4, 2));
  endtask

  task automatic runWave(int da, int db, int len, string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, {tag, "_rst"});
    for (int i = 0; i < len; i++) begin
      applyStimulus(i >= da, i >= db, 1'b0, tag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    t        = 0;
    a        = 1'b0;
    b        = 1'b0;
    rst      = 1'b0;
    grst     = 1'b0;
    modelGlobalReset();
    #12;
    checkOutput("reset", 1'b0, 1'b0);
    @(negedge aclk);
    grst = 1'b1;

    // no events for 40 cycles
    runWave(100, 100, 40, "idle");

    runWave(10, 20, 30, "a_then_b");
    runWave(20, 10, 30, "b_then_a");
    runWave(10, 10, 20, "simul");
    runWave(0, 0, 10, "first_cycle");
    runWave(10, 11, 20, "sep1");
    runWave(10, 12, 20, "sep2");
    runWave(10, 13, 20, "sep3");
    runWave(7, 5, 20, "sep2_rev");

    // b falls and rises again after a miss
    applyStimulus(1'b0, 1'b0, 1'b1, "rerise_rst");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(i >= 10, (i >= 20 && i < 25) || i >= 28, 1'b0, "rerise");
    end

    // rst truncates a pulse while both inputs stay high through release
    applyStimulus(1'b0, 1'b0, 1'b1, "trunc_rst");
    for (int i = 0; i < 12; i++) applyStimulus(i >= 10, i >= 10, 1'b0, "trunc_pre");
    applyStimulus(1'b1, 1'b1, 1'b1, "trunc_hit");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, "trunc_hold");

    // asynchronous global reset in the middle of a pulse
    applyStimulus(1'b0, 1'b0, 1'b1, "grst_rst");
    applyStimulus(1'b0, 1'b0, 1'b0, "grst_pre");
    applyStimulus(1'b1, 1'b1, 1'b0, "grst_fire");
    #2;
    grst = 1'b0;
    modelGlobalReset();
    #1;
    checkOutput("grst_async", 1'b0, 1'b0);
    @(negedge aclk);
    grst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, "grst_held");
    applyStimulus(1'b0, 1'b0, 1'b0, "grst_low");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, "grst_after");

    // random activity with occasional wave resets
    for (int i = 0; i < 600; i++) begin
      logic na;
      logic nb;
      logic nr;
      na = (($urandom % 4) == 0) ? ~a : a;
      nb = (($urandom % 4) == 0) ? ~b : b;
      nr = (($urandom % 16) == 0);
      applyStimulus(na, nb, nr, "random");
    end

    $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/equal.md
EQUAL -- requirements
Module: equal

Interface
REQ-001 Parameter TOL, default 1: max arrival separation in aclk cycles still judged equal; used only when EQUAL_TOL_EN is defined; legal range 0..15.
REQ-002 Parameter PULSE_W, default 1: width of y pulse in aclk cycles; legal range 1..15.
REQ-003 aclk  input  1  the single clock; all state updates on rising edge.
REQ-004 grst  input  1  asynchronous, active-low global reset.
REQ-005 rst  input  1  synchronous, active-high wave reset; clears per-wave state between computations.
REQ-006 a  input  1  temporal operand A; event = low-to-high transition sampled on aclk.
REQ-007 b  input  1  temporal operand B; same encoding as a.
REQ-008 y  output  1  registered; emits PULSE_W-cycle high pulse when a and b events are judged simultaneous.

Function
REQ-009 Per input: prev register holds last sampled level; event when input=1 and prev=0 at an aclk edge.
REQ-010 Per input: arrival flag set on first event in a wave; later events of that input in the same wave ignored.
REQ-011 Base rule: a and b events at the same aclk edge -> y=1 from that edge for PULSE_W cycles, then 0.
REQ-012 Events at different edges: no y pulse for that wave.
REQ-013 At most one y pulse per wave; after any y decision (fire or miss), further input activity ignored until rst.
REQ-014 No event on either input: y stays 0 indefinitely.
REQ-015 Input already high at wave start: not an event; requires a fall then rise.
REQ-016 Latency: y visible immediately after the aclk edge that samples the qualifying event(s); no extra pipeline cycles.

Reset
REQ-017 grst=0: asynchronously y=0, arrival flags=0, pulse and separation counters=0, prev registers=1.
REQ-018 rst=1 at an aclk edge: y=0, flags and counters=0, prev loaded with current input level; rst has priority over any simultaneous event.
REQ-019 rst asserted during a y pulse truncates it: y=0 after that edge.
REQ-020 Input rising in the first cycle after rst deassertion is a valid event.

Configuration
REQ-021 Macro EQUAL_TOL_EN defined: after first arrival, separation counter counts aclk edges; second arrival with separation <= TOL fires y on the second arrival's edge; separation > TOL is a miss, decided when the counter exceeds TOL.
REQ-022 EQUAL_TOL_EN undefined: TOL ignored; separation counter not built; only same-edge arrivals fire (REQ-011).

Structure
REQ-023 Package equal_pkg holds TOL and PULSE_W defaults plus a 4-bit count typedef shared by the separation and pulse counters.
REQ-024 Sub-module equal_arrival (edge detect, arrival flag, rst/grst handling) is instantiated once for a and once for b.
REQ-025 Top level holds the decision logic, separation counter and y pulse counter.

Verification
REQ-026 No events for 40 cycles after rst -> y=0 throughout.
REQ-027 a rises at cycle 10, b at cycle 20, EQUAL_TOL_EN undefined -> y=0 throughout; second b rise after a fall before rst -> y stays 0.
REQ-028 b rises at cycle 10, a at cycle 20 -> y=0; a and b both rise at cycle 10 -> y=1 during cycle 10 only (PULSE_W=1), 0 afterwards.
REQ-029 EQUAL_TOL_EN defined, TOL=2: a rises at cycle 10, b at 12 -> y=1 during cycle 12; b at 13 -> y=0.
REQ-030 PULSE_W=4, simultaneous rise at cycle 10, rst at cycle 12 -> y high in cycles 10-11, 0 from cycle 12; a and b held high through rst deassertion -> no new pulse.
REQ-031 grst low mid-wave -> y=0 immediately with no aclk edge; after release, simultaneous rise of both inputs -> one y pulse.
